// File: rtl/hex_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// hex_cmd_parser_if
// Groups the byte stream from the serial receiver and the command handshake
// toward the calculator ALU.
//   RX_DATA_T  [9:0]  received byte: [7:0] data, [8] parity err, [9] frame err
//   RX_DATA_EN        one-cycle strobe, RX_DATA_T valid
//   CMD_READY         ALU accepts the command
//   CMD_VALID         command available; OP_A/OP_B/OP_CODE stable while high
//   OP_A, OP_B [W-1:0] binary operands, W = 4*MAX_DIGITS
//   OP_CODE   [2:0]   0 add, 1 sub, 2 and, 3 or, 4 xor
//   ERR_STB           one-cycle error pulse
//   ERR_CODE  [2:0]   last error: 1 frame, 2 parity, 3 syntax, 4 overflow, 5 overrun
// Modports: master = byte source / ALU side, slave = parser.
// -----------------------------------------------------------------------------
interface hex_cmd_parser_if #(
    parameter int MAX_DIGITS = 4
);
    localparam int W = 4 * MAX_DIGITS;

    logic [9:0]   RX_DATA_T;
    logic         RX_DATA_EN;
    logic         CMD_READY;
    logic         CMD_VALID;
    logic [W-1:0] OP_A;
    logic [W-1:0] OP_B;
    logic [2:0]   OP_CODE;
    logic         ERR_STB;
    logic [2:0]   ERR_CODE;

    modport master (
        output RX_DATA_T, RX_DATA_EN, CMD_READY,
        input  CMD_VALID, OP_A, OP_B, OP_CODE, ERR_STB, ERR_CODE
    );

    modport slave (
        input  RX_DATA_T, RX_DATA_EN, CMD_READY,
        output CMD_VALID, OP_A, OP_B, OP_CODE, ERR_STB, ERR_CODE
    );
endinterface

// File: rtl/hex_cmd_parser.sv
// -----------------------------------------------------------------------------
// hex_cmd_parser
// Parses ASCII hex calculator commands "AAAA<op>BBBB<term>" from the received
// byte stream into binary operands plus opcode, presented under a valid/ready
// handshake. Line errors (frame/parity) and syntax errors are reported on
// ERR_STB/ERR_CODE and the rest of the offending line is flushed.
// Ports:
//   CLK    system clock
//   RST_N  asynchronous reset, active low
//   bus    hex_cmd_parser_if.slave (byte input, command output, error report)
// Build option:
//   HEX_PARSER_LOWERCASE_EN  when defined, 'a'-'f' are accepted as digits 10-15
// -----------------------------------------------------------------------------
module hex_cmd_parser #(
    parameter int MAX_DIGITS = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    hex_cmd_parser_if.slave        bus
);
    localparam int W  = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    localparam logic [2:0] ERR_FRAME    = 3'd1;
    localparam logic [2:0] ERR_PARITY   = 3'd2;
    localparam logic [2:0] ERR_SYNTAX   = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW = 3'd4;
    localparam logic [2:0] ERR_OVERRUN  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_OPA      = 3'd1,
        ST_OPB      = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_ERR_FLUSH = 3'd4
    } state_t;

    state_t        state_r;
    logic [CW-1:0] count_r;
    logic [W-1:0]  op_a_r;
    logic [W-1:0]  op_b_r;
    logic [2:0]    op_code_r;
    logic          cmd_valid_r;
    logic          err_stb_r;
    logic [2:0]    err_code_r;

    logic [7:0]    rx_byte_s;
    logic          frame_err_s;
    logic          parity_err_s;
    logic          line_err_s;
    logic [2:0]    line_err_code_s;
    logic          is_digit_s;
    logic [3:0]    digit_s;
    logic          is_op_s;
    logic [2:0]    opc_s;
    logic          is_term_s;
    logic          is_space_s;

    assign rx_byte_s    = bus.RX_DATA_T[7:0];
    assign parity_err_s = bus.RX_DATA_T[8];
    assign frame_err_s  = bus.RX_DATA_T[9];
    assign line_err_s   = frame_err_s | parity_err_s;

    // Frame error outranks parity error when both flags are set.
    always_comb begin
        if (frame_err_s) begin
            line_err_code_s = ERR_FRAME;
        end else begin
            line_err_code_s = ERR_PARITY;
        end
    end

    // Classify the incoming character into digit / operator / terminator / space.
    always_comb begin
        is_digit_s = 1'b0;
        digit_s    = 4'h0;
        is_op_s    = 1'b0;
        opc_s      = 3'd0;
        is_term_s  = 1'b0;
        is_space_s = 1'b0;
        if ((rx_byte_s >= 8'h30) && (rx_byte_s <= 8'h39)) begin
            is_digit_s = 1'b1;
            digit_s    = rx_byte_s[3:0];
        end else if ((rx_byte_s >= 8'h41) && (rx_byte_s <= 8'h46)) begin
            // 'A' is 0x41: low nibble 1 maps to 10
            is_digit_s = 1'b1;
            digit_s    = rx_byte_s[3:0] + 4'd9;
`ifdef HEX_PARSER_LOWERCASE_EN
        end else if ((rx_byte_s >= 8'h61) && (rx_byte_s <= 8'h66)) begin
            is_digit_s = 1'b1;
            digit_s    = rx_byte_s[3:0] + 4'd9;
`endif
        end else begin
            case (rx_byte_s)
                8'h2B: begin is_op_s = 1'b1; opc_s = 3'd0; end
                8'h2D: begin is_op_s = 1'b1; opc_s = 3'd1; end
                8'h26: begin is_op_s = 1'b1; opc_s = 3'd2; end
                8'h7C: begin is_op_s = 1'b1; opc_s = 3'd3; end
                8'h5E: begin is_op_s = 1'b1; opc_s = 3'd4; end
                8'h3D: is_term_s  = 1'b1;
                8'h0D: is_term_s  = 1'b1;
                8'h20: is_space_s = 1'b1;
                default: is_op_s  = 1'b0;
            endcase
        end
    end

    // Parser FSM with all outputs registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            count_r     <= '0;
            op_a_r      <= '0;
            op_b_r      <= '0;
            op_code_r   <= 3'd0;
            cmd_valid_r <= 1'b0;
            err_stb_r   <= 1'b0;
            err_code_r  <= 3'd0;
        end else begin
            err_stb_r <= 1'b0;
            case (state_r)
                ST_WAIT_ACK: begin
                    if (bus.CMD_READY) begin
                        cmd_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                    // Any byte arriving while a command is pending is dropped.
                    if (bus.RX_DATA_EN) begin
                        err_stb_r  <= 1'b1;
                        err_code_r <= ERR_OVERRUN;
                    end
                end

                ST_ERR_FLUSH: begin
                    // Only a clean terminator ends the flush; errored bytes stay silent.
                    if (bus.RX_DATA_EN && !line_err_s && is_term_s) begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_IDLE, ST_OPA, ST_OPB: begin
                    if (bus.RX_DATA_EN) begin
                        if (line_err_s) begin
                            err_stb_r  <= 1'b1;
                            err_code_r <= line_err_code_s;
                            state_r    <= ST_ERR_FLUSH;
                        end else begin
                            case (state_r)
                                ST_IDLE: begin
                                    if (is_digit_s) begin
                                        op_a_r  <= {{(W-4){1'b0}}, digit_s};
                                        op_b_r  <= '0;
                                        count_r <= CW'(1);
                                        state_r <= ST_OPA;
                                    end else if (is_space_s || is_term_s) begin
                                        state_r <= ST_IDLE;
                                    end else begin
                                        err_stb_r  <= 1'b1;
                                        err_code_r <= ERR_SYNTAX;
                                        state_r    <= ST_ERR_FLUSH;
                                    end
                                end

                                ST_OPA: begin
                                    if (is_digit_s) begin
                                        if (count_r < MAX_CNT) begin
                                            op_a_r  <= {op_a_r[W-5:0], digit_s};
                                            count_r <= count_r + CW'(1);
                                        end else begin
                                            err_stb_r  <= 1'b1;
                                            err_code_r <= ERR_OVERFLOW;
                                            state_r    <= ST_ERR_FLUSH;
                                        end
                                    end else if (is_op_s) begin
                                        op_code_r <= opc_s;
                                        count_r   <= '0;
                                        state_r   <= ST_OPB;
                                    end else if (is_term_s) begin
                                        // Line already ended: no flush needed.
                                        err_stb_r  <= 1'b1;
                                        err_code_r <= ERR_SYNTAX;
                                        state_r    <= ST_IDLE;
                                    end else if (is_space_s) begin
                                        state_r <= ST_OPA;
                                    end else begin
                                        err_stb_r  <= 1'b1;
                                        err_code_r <= ERR_SYNTAX;
                                        state_r    <= ST_ERR_FLUSH;
                                    end
                                end

                                ST_OPB: begin
                                    if (is_digit_s) begin
                                        if (count_r < MAX_CNT) begin
                                            op_b_r  <= {op_b_r[W-5:0], digit_s};
                                            count_r <= count_r + CW'(1);
                                        end else begin
                                            err_stb_r  <= 1'b1;
                                            err_code_r <= ERR_OVERFLOW;
                                            state_r    <= ST_ERR_FLUSH;
                                        end
                                    end else if (is_term_s) begin
                                        if (count_r != '0) begin
                                            cmd_valid_r <= 1'b1;
                                            state_r     <= ST_WAIT_ACK;
                                        end else begin
                                            err_stb_r  <= 1'b1;
                                            err_code_r <= ERR_SYNTAX;
                                            state_r    <= ST_IDLE;
                                        end
                                    end else if (is_space_s) begin
                                        state_r <= ST_OPB;
                                    end else begin
                                        err_stb_r  <= 1'b1;
                                        err_code_r <= ERR_SYNTAX;
                                        state_r    <= ST_ERR_FLUSH;
                                    end
                                end

                                default: state_r <= ST_IDLE;
                            endcase
                        end
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    cmd_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CMD_VALID = cmd_valid_r;
    assign bus.OP_A      = op_a_r;
    assign bus.OP_B      = op_b_r;
    assign bus.OP_CODE   = op_code_r;
    assign bus.ERR_STB   = err_stb_r;
    assign bus.ERR_CODE  = err_code_r;

endmodule

// File: tb/tb_hex_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_hex_cmd_parser
// Directed bench for hex_cmd_parser: byte strings are streamed one per cycle,
// outputs are compared on the falling edge against hand-computed values.
// Honours HEX_PARSER_LOWERCASE_EN for the lowercase-digit step.
// -----------------------------------------------------------------------------
module tb_hex_cmd_parser;
    logic CLK;
    logic RST_N;

    int n_checks;
    int n_fail;
    int err_pulses;
    int e0;

    hex_cmd_parser_if #(.MAX_DIGITS(4)) bus ();

    hex_cmd_parser #(.MAX_DIGITS(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count every cycle in which the error strobe is high.
    always @(posedge CLK) begin
        if (bus.ERR_STB === 1'b1) err_pulses <= err_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is sampled.
    task automatic send(input logic [7:0] b, input logic [1:0] errs);
        bus.RX_DATA_T  = {errs, b};
        bus.RX_DATA_EN = 1'b1;
        @(negedge CLK);
        bus.RX_DATA_EN = 1'b0;
        bus.RX_DATA_T  = 10'h000;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 2'b00);
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic ack();
        bus.CMD_READY = 1'b1;
        @(negedge CLK);
        bus.CMD_READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        err_pulses = 0;
        RST_N = 1'b0;
        bus.RX_DATA_T = 10'h000;
        bus.RX_DATA_EN = 1'b0;
        bus.CMD_READY = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset state
        check("rst_valid", 32'(bus.CMD_VALID), 32'd0);
        check("rst_op_a", 32'(bus.OP_A), 32'h0);
        check("rst_err_code", 32'(bus.ERR_CODE), 32'd0);
        check("rst_err_stb", 32'(bus.ERR_STB), 32'd0);
        RST_N = 1'b1;
        tick();

        // "12A+3F=" held while CMD_READY low
        send_str("12A+3F=");
        check("t1_valid", 32'(bus.CMD_VALID), 32'd1);
        check("t1_op_a", 32'(bus.OP_A), 32'h012A);
        check("t1_op_b", 32'(bus.OP_B), 32'h003F);
        check("t1_opcode", 32'(bus.OP_CODE), 32'd0);
        repeat (3) tick();
        check("t1_hold_valid", 32'(bus.CMD_VALID), 32'd1);
        check("t1_hold_op_a", 32'(bus.OP_A), 32'h012A);
        check("t1_no_err", 32'(err_pulses), 32'd0);
        ack();
        check("t1_ack_valid", 32'(bus.CMD_VALID), 32'd0);

        // "FFFF^ 1" CR, then digit overflow on "12345"
        send_str("FFFF^ 1");
        send(8'h0D, 2'b00);
        check("t2_valid", 32'(bus.CMD_VALID), 32'd1);
        check("t2_op_a", 32'(bus.OP_A), 32'hFFFF);
        check("t2_op_b", 32'(bus.OP_B), 32'h0001);
        check("t2_opcode", 32'(bus.OP_CODE), 32'd4);
        ack();
        check("t2_ack_valid", 32'(bus.CMD_VALID), 32'd0);
        e0 = err_pulses;
        send_str("12345");
        check("t2_ovf_stb", 32'(bus.ERR_STB), 32'd1);
        check("t2_ovf_code", 32'(bus.ERR_CODE), 32'd4);
        tick();
        check("t2_ovf_stb_one_cycle", 32'(bus.ERR_STB), 32'd0);
        check("t2_ovf_pulses", 32'(err_pulses - e0), 32'd1);
        send_str("=");
        check("t2_no_valid", 32'(bus.CMD_VALID), 32'd0);

        // Frame+parity byte mid-operand A, flushed line, then clean command
        e0 = err_pulses;
        send_str("1");
        send(8'h37, 2'b11);
        check("t3_frame_stb", 32'(bus.ERR_STB), 32'd1);
        check("t3_frame_code", 32'(bus.ERR_CODE), 32'd1);
        send_str("1+1=");
        tick();
        check("t3_flush_valid", 32'(bus.CMD_VALID), 32'd0);
        check("t3_pulses", 32'(err_pulses - e0), 32'd1);
        send_str("2-1=");
        check("t3_valid", 32'(bus.CMD_VALID), 32'd1);
        check("t3_op_a", 32'(bus.OP_A), 32'h0002);
        check("t3_op_b", 32'(bus.OP_B), 32'h0001);
        check("t3_opcode", 32'(bus.OP_CODE), 32'd1);

        // Overrun while CMD_VALID high, then ready together with a byte
        e0 = err_pulses;
        send_str("5");
        check("t4_ovr_stb", 32'(bus.ERR_STB), 32'd1);
        check("t4_ovr_code", 32'(bus.ERR_CODE), 32'd5);
        check("t4_hold_valid", 32'(bus.CMD_VALID), 32'd1);
        check("t4_hold_op_a", 32'(bus.OP_A), 32'h0002);
        check("t4_hold_op_b", 32'(bus.OP_B), 32'h0001);
        check("t4_hold_opcode", 32'(bus.OP_CODE), 32'd1);
        bus.CMD_READY = 1'b1;
        send(8'h36, 2'b00);
        bus.CMD_READY = 1'b0;
        check("t4_ack_valid", 32'(bus.CMD_VALID), 32'd0);
        check("t4_ack_stb", 32'(bus.ERR_STB), 32'd1);
        check("t4_ack_code", 32'(bus.ERR_CODE), 32'd5);
        tick();
        check("t4_pulses", 32'(err_pulses - e0), 32'd2);

        // Syntax errors: leading operator, missing operator, lowercase digits
        e0 = err_pulses;
        send_str("+5=");
        check("t5_lead_op_code", 32'(bus.ERR_CODE), 32'd3);
        check("t5_lead_op_valid", 32'(bus.CMD_VALID), 32'd0);
        tick();
        check("t5_lead_op_pulses", 32'(err_pulses - e0), 32'd1);
        send_str("5=");
        check("t5_noop_stb", 32'(bus.ERR_STB), 32'd1);
        check("t5_noop_code", 32'(bus.ERR_CODE), 32'd3);
        tick();
        e0 = err_pulses;
        send_str("a+b=");
        tick();
`ifdef HEX_PARSER_LOWERCASE_EN
        check("t5_lc_valid", 32'(bus.CMD_VALID), 32'd1);
        check("t5_lc_op_a", 32'(bus.OP_A), 32'h000A);
        check("t5_lc_op_b", 32'(bus.OP_B), 32'h000B);
        check("t5_lc_opcode", 32'(bus.OP_CODE), 32'd0);
        check("t5_lc_pulses", 32'(err_pulses - e0), 32'd0);
        ack();
`else
        check("t5_lc_valid", 32'(bus.CMD_VALID), 32'd0);
        check("t5_lc_code", 32'(bus.ERR_CODE), 32'd3);
        check("t5_lc_pulses", 32'(err_pulses - e0), 32'd1);
`endif

        // Reset while in OPB, then a fresh command
        send_str("12+3");
        RST_N = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.CMD_VALID), 32'd0);
        check("t6_rst_op_a", 32'(bus.OP_A), 32'h0);
        check("t6_rst_op_b", 32'(bus.OP_B), 32'h0);
        check("t6_rst_opcode", 32'(bus.OP_CODE), 32'd0);
        check("t6_rst_err_code", 32'(bus.ERR_CODE), 32'd0);
        tick();
        RST_N = 1'b1;
        tick();
        send_str("1|2=");
        check("t6_valid", 32'(bus.CMD_VALID), 32'd1);
        check("t6_opcode", 32'(bus.OP_CODE), 32'd3);
        check("t6_op_a", 32'(bus.OP_A), 32'h0001);
        check("t6_op_b", 32'(bus.OP_B), 32'h0002);
        check("t6_err_code", 32'(bus.ERR_CODE), 32'd0);
        ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
